// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op/state encodings and default widths for the multiply/divide unit.
`default_nettype none

package mul_div_unit_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_REG_ADDR_W = 3;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_datapath.sv
// mul_div_datapath: shift-add multiplier / restoring divider step logic, accumulator and result mux.
`default_nettype none

module mul_div_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_capture,
  input  logic             i_bypass,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_by_zero
);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_sel;

  always_comb begin
    w_addend   = r_mplr[0] ? r_a : {WIDTH{1'b0}};
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Remainder gets one extra bit so the shifted value never overflows before the trial subtract.
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    w_div_next = w_diff[WIDTH+1] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    w_acc_next = r_acc;
    if (i_step) begin
      w_acc_next = is_div_op(r_op) ? w_div_next : w_mul_next;
    end

    w_div_zero = is_div_op(r_op) && (r_b == {WIDTH{1'b0}});

    case (r_op)
      OP_MUL:  w_sel = w_acc_next[WIDTH-1:0];
      OP_MULH: w_sel = w_acc_next[2*WIDTH-1:WIDTH];
      OP_DIV:  w_sel = w_div_zero ? {WIDTH{1'b1}} : w_acc_next[WIDTH-1:0];
      default: w_sel = w_div_zero ? r_a : w_acc_next[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      if (i_load) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_op   <= i_op;
        r_mplr <= i_b;
        r_acc  <= is_div_op(i_op) ? {{WIDTH{1'b0}}, i_a} : {2*WIDTH{1'b0}};
        r_dbz  <= 1'b0;
      end else if (i_step) begin
        r_acc  <= w_acc_next;
        r_mplr <= {1'b0, r_mplr[WIDTH-1:1]};
      end
      // Capture on the edge entering FINISH so the output is valid throughout that cycle.
      if (i_capture) begin
        r_result <= i_bypass ? {WIDTH{1'b0}} : w_sel;
        r_dbz    <= ~i_bypass & w_div_zero;
      end
    end
  end

  assign o_result      = r_result;
  assign o_div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned MUL/MULH/DIV/REM with register-file write handshake.
// Optional MULDIV_ZERO_BYPASS_EN: zero-operand MUL/MULH and zero-dividend DIV/REM finish in one cycle.
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  input  logic [REG_ADDR_W-1:0] DestReg,
  output logic                  Busy,
  output logic                  Done,
  output logic                  WriteEn,
  output logic [REG_ADDR_W-1:0] ResultReg,
  output logic [WIDTH-1:0]      Result,
  output logic                  DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] r_result_reg;
  logic                  w_load;
  logic                  w_step;
  logic                  w_capture;
  logic                  w_bypass;
  logic                  w_last;

`ifdef MULDIV_ZERO_BYPASS_EN
  assign w_bypass = is_div_op(Op) ? ((OperandA == '0) && (OperandB != '0))
                                  : ((OperandA == '0) || (OperandB == '0));
`else
  assign w_bypass = 1'b0;
`endif

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load = 1'b1;
          if (w_bypass) begin
            w_capture    = 1'b1;
            w_state_next = ST_FINISH;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_capture    = 1'b1;
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dest       <= '0;
      r_result_reg <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt  <= '0;
        r_dest <= DestReg;
      end else if (w_step) begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_result_reg <= w_load ? DestReg : r_dest;
      end
    end
  end

  mul_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_capture    (w_capture),
    .i_bypass     (w_bypass & w_load),
    .i_op         (Op),
    .i_a          (OperandA),
    .i_b          (OperandB),
    .o_result     (Result),
    .o_div_by_zero(DivByZero)
  );

  assign Busy      = (r_state != ST_IDLE);
  assign Done      = (r_state == ST_FINISH);
  assign WriteEn   = Done;
  assign ResultReg = r_result_reg;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
`default_nettype none

module tb_mul_div_unit;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic [1:0] Op;
  logic [7:0] OperandA;
  logic [7:0] OperandB;
  logic [2:0] DestReg;
  logic       Busy;
  logic       Done;
  logic       WriteEn;
  logic [2:0] ResultReg;
  logic [7:0] Result;
  logic       DivByZero;

  int tests;
  int fails;

  mul_div_unit dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .DestReg  (DestReg),
    .Busy     (Busy),
    .Done     (Done),
    .WriteEn  (WriteEn),
    .ResultReg(ResultReg),
    .Result   (Result),
    .DivByZero(DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  // Issues one operation and waits (bounded) for Done; lat counts edges from the Start edge inclusive.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dest, output int lat, output logic [7:0] res,
                        output logic dbz, output logic [2:0] rreg, output logic we);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestReg = dest;
    @(posedge Clock); #1;
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    res = Result; dbz = DivByZero; rreg = ResultReg; we = WriteEn;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = 8'h00; OperandB = 8'h00; DestReg = 3'd0;
    repeat (2) @(posedge Clock);
    #1;
    tests++;
    if ({Busy, Done, WriteEn, DivByZero} !== 4'b0000 || Result !== 8'h00 || ResultReg !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b we=%b dbz=%b res=%h rreg=%0d, required all zero",
               Busy, Done, WriteEn, DivByZero, Result, ResultReg);
    end
    Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_mul();
    int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    run_op(2'b00, 8'd13, 8'd11, 3'd5, lat, res, dbz, rreg, we);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL mul_latency: got %0d, required 9", lat); end
    tests++;
    if (res !== 8'h8F || rreg !== 3'd5 || dbz !== 1'b0 || we !== 1'b1) begin
      fails++;
      $display("FAIL mul_13x11: res=%h rreg=%0d dbz=%b we=%b, required 8f 5 0 1", res, rreg, dbz, we);
    end
    tests++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Result !== 8'h8F) begin
      fails++;
      $display("FAIL mul_after_done: done=%b busy=%b res=%h, required 0 0 8f", Done, Busy, Result);
    end
  endtask

  task automatic test_mulh();
    int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    run_op(2'b00, 8'd200, 8'd3, 3'd1, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'h58) begin fails++; $display("FAIL mul_200x3: got %h, required 58", res); end
    run_op(2'b01, 8'd200, 8'd3, 3'd2, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'h02 || rreg !== 3'd2) begin
      fails++; $display("FAIL mulh_200x3: res=%h rreg=%0d, required 02 2", res, rreg);
    end
    run_op(2'b00, 8'd255, 8'd255, 3'd3, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'h01) begin fails++; $display("FAIL mul_255x255: got %h, required 01", res); end
    run_op(2'b01, 8'd255, 8'd255, 3'd3, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'hFE) begin fails++; $display("FAIL mulh_255x255: got %h, required fe", res); end
  endtask

  task automatic test_div_rem();
    int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    run_op(2'b10, 8'd100, 8'd7, 3'd4, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd14 || lat !== 9 || dbz !== 1'b0) begin
      fails++; $display("FAIL div_100_7: res=%0d lat=%0d dbz=%b, required 14 9 0", res, lat, dbz);
    end
    run_op(2'b11, 8'd100, 8'd7, 3'd4, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd2) begin fails++; $display("FAIL rem_100_7: got %0d, required 2", res); end
    run_op(2'b10, 8'd7, 8'd100, 3'd6, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd0) begin fails++; $display("FAIL div_7_100: got %0d, required 0", res); end
    run_op(2'b11, 8'd7, 8'd100, 3'd6, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd7) begin fails++; $display("FAIL rem_7_100: got %0d, required 7", res); end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    run_op(2'b10, 8'd42, 8'd0, 3'd7, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'hFF || dbz !== 1'b1 || lat !== 9) begin
      fails++; $display("FAIL div_by_zero: res=%h dbz=%b lat=%0d, required ff 1 9", res, dbz, lat);
    end
    tests++;
    if (DivByZero !== 1'b1) begin
      fails++; $display("FAIL dbz_hold: got %b, required 1", DivByZero);
    end
    run_op(2'b11, 8'd42, 8'd0, 3'd7, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd42 || dbz !== 1'b1) begin
      fails++; $display("FAIL rem_by_zero: res=%0d dbz=%b, required 42 1", res, dbz);
    end
    run_op(2'b00, 8'd3, 8'd4, 3'd1, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd12 || dbz !== 1'b0) begin
      fails++; $display("FAIL dbz_clear: res=%0d dbz=%b, required 12 0", res, dbz);
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt; int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    logic [7:0] first_res; logic [2:0] first_reg; logic busy_after;
    done_cnt = 0; first_res = 8'h00; first_reg = 3'd0; busy_after = 1'b1;
    Start = 1'b1; Op = 2'b00; OperandA = 8'd13; OperandB = 8'd11; DestReg = 3'd5;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      if (cyc == 2 || cyc == 7) begin
        Start = 1'b1; OperandA = 8'd2; OperandB = 8'd2; DestReg = 3'd1;
      end else begin
        OperandA = 8'd9; OperandB = 8'd9;
      end
      if (Done === 1'b1) begin
        done_cnt++;
        first_res = Result; first_reg = ResultReg;
      end
      if (cyc == 10) busy_after = Busy;
    end
    tests++;
    if (done_cnt !== 1 || first_res !== 8'h8F || first_reg !== 3'd5) begin
      fails++;
      $display("FAIL start_while_busy: dones=%0d res=%h rreg=%0d, required 1 8f 5",
               done_cnt, first_res, first_reg);
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL idle_after_done: busy=%b, required 0", busy_after);
    end
    run_op(2'b00, 8'd2, 8'd2, 3'd1, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd4 || rreg !== 3'd1) begin
      fails++; $display("FAIL restart_after_idle: res=%0d rreg=%0d, required 4 1", res, rreg);
    end
  endtask

  task automatic test_reset_mid_op();
    int we_seen;
    we_seen = 0;
    Start = 1'b1; Op = 2'b10; OperandA = 8'd100; OperandB = 8'd7; DestReg = 3'd3;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 8'h00 || ResultReg !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid_op: busy=%b done=%b res=%h rreg=%0d, required 0 0 00 0",
               Busy, Done, Result, ResultReg);
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge Clock); #1;
      if (cyc == 2) Resetn = 1'b1;
      if (WriteEn === 1'b1) we_seen++;
    end
    tests++;
    if (we_seen !== 0) begin
      fails++; $display("FAIL aborted_writeen: seen %0d strobes, required 0", we_seen);
    end
  endtask

  task automatic test_zero_bypass();
    int lat; logic [7:0] res; logic dbz; logic [2:0] rreg; logic we;
    int exp_lat;
`ifdef MULDIV_ZERO_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 9;
`endif
    run_op(2'b00, 8'd0, 8'd9, 3'd2, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'd0 || lat !== exp_lat || rreg !== 3'd2 || we !== 1'b1) begin
      fails++;
      $display("FAIL zero_mul: res=%0d lat=%0d rreg=%0d we=%b, required 0 %0d 2 1",
               res, lat, rreg, we, exp_lat);
    end
    run_op(2'b10, 8'd0, 8'd0, 3'd2, lat, res, dbz, rreg, we);
    tests++;
    if (res !== 8'hFF || lat !== 9 || dbz !== 1'b1) begin
      fails++; $display("FAIL zero_div_by_zero: res=%h lat=%0d dbz=%b, required ff 9 1", res, lat, dbz);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_div_rem();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_zero_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
